alu_mul_sequencer: RTL



---
 rtl/mips_alu_pkg.sv | 13 +
 rtl/alu_mul_sequencer_if.sv | 25 ++
 rtl/alu_mul_sequencer.sv | 59 +++++
 3 files changed

// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: shared ALU control codes and multiply-sequencer state encoding
package mips_alu_pkg;
  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd7,
    ALU_NOR = 4'd12,
    ALU_NOP = 4'd15
  } alu_op_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/alu_mul_sequencer_if.sv
// alu_mul_sequencer_if: execute-stage handshake (start/op_a/op_b -> busy/done/result/result_zero)
// plus the shared combinational ALU bus (alu_ctrl/alu_a/alu_b -> alu_result/alu_zero).
// master = execute stage + ALU side, slave = the sequencer.
interface alu_mul_sequencer_if;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        result_zero;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_zero;
  modport master (
    output start, op_a, op_b, alu_result, alu_zero,
    input  busy, done, result, result_zero, alu_ctrl, alu_a, alu_b
  );
  modport slave (
    input  start, op_a, op_b, alu_result, alu_zero,
    output busy, done, result, result_zero, alu_ctrl, alu_a, alu_b
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: low 32 bits of an unsigned 32x32 product by shift-and-add on the shared ALU.
// Ports: clk, rst_n (async active-low), bus (slave: start/op_a/op_b in, busy/done/result/result_zero
// out, alu_ctrl/alu_a/alu_b out to the parent's ALU, alu_result/alu_zero back from it).
module alu_mul_sequencer
  import mips_alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input logic clk,
  input logic rst_n,
  alu_mul_sequencer_if.slave bus
);
  state_t state, state_nxt;
  logic [WIDTH-1:0] acc, mcand, mplier, result_q;
  logic [5:0] count;
  logic zero_q, last;
  // Early exit looks at the multiplier as it will be after this iteration's shift.
  assign last = count == 6'(WIDTH - 1) || (EARLY_EXIT && mplier[WIDTH-1:1] == '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE ? (bus.start ? RUN : IDLE) :
                state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      count    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      acc    <= '0;
      mcand  <= bus.op_a;
      mplier <= bus.op_b;
      count  <= '0;
    end else if (state == RUN) begin
      acc    <= bus.alu_result;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 6'd1;
      if (last) begin
        result_q <= bus.alu_result;
        zero_q   <= bus.alu_zero;
      end
    end
  always_comb begin
    bus.busy        = state != IDLE;
    bus.done        = state == DONE;
    bus.alu_ctrl    = state == RUN ? ALU_ADD : ALU_NOP;
    bus.alu_a       = state == RUN ? acc : '0;
    bus.alu_b       = state == RUN && mplier[0] ? mcand : '0;
    bus.result      = result_q;
    bus.result_zero = zero_q;
  end
endmodule
